// File: rtl/vga_timing_rx.sv
// VGA timing receiver: samples hsync/vsync/rgb on pixel ticks, locks onto the
// sync timing, recovers the pixel coordinates and counts timing errors.
module vga_timing_rx #(
  parameter int unsigned H_DISPLAY    = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_DISPLAY    = 480,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned SYNC_POL     = 1,
  parameter int unsigned LOCK_LINES   = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        p_tick_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [11:0] rgb_i,
  output logic [9:0]  x_o,
  output logic [9:0]  y_o,
  output logic        video_on_o,
  output logic [11:0] pix_rgb_o,
  output logic        frame_start_o,
  output logic        locked_o,
  output logic [7:0]  err_count_o
);

  localparam int unsigned CntW = $clog2(LOCK_LINES + 1);

  localparam logic              Pol        = (SYNC_POL != 0);
  localparam logic [9:0]        HSyncStart = 10'(H_SYNC_START);
  localparam logic [9:0]        HLast      = 10'(H_TOTAL - 1);
  localparam logic [9:0]        HDisp      = 10'(H_DISPLAY);
  localparam logic [9:0]        VSyncStart = 10'(V_SYNC_START);
  localparam logic [9:0]        VLast      = 10'(V_TOTAL - 1);
  localparam logic [9:0]        VDisp      = 10'(V_DISPLAY);
  localparam logic [10:0]       WdLast     = 11'(2 * H_TOTAL - 1);
  localparam logic [CntW-1:0]   GoodLast   = CntW'(LOCK_LINES - 1);

  typedef enum logic [1:0] {StSearch, StSyncH, StSyncV, StLocked} state_e;

  state_e          state_q, state_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic [9:0]      x_pred, y_pred;
  logic            hs_q, vs_q;
  logic            hs_act, vs_act, hs_edge, vs_edge;
  logic            x_wrap, h_match, v_match, timeout, err_inc;
  logic [CntW-1:0] good_q, good_d;
  logic [10:0]     wd_q, wd_d;
  logic [7:0]      err_q, err_d;
  logic            video_on_q, video_on_d;
  logic [11:0]     pix_q, pix_d;
  logic            fs_q, fs_d;

  // Edge detection, coordinate prediction, lock FSM and output next-state.
  always_comb begin
    hs_act  = (hsync_i == Pol);
    vs_act  = (vsync_i == Pol);
    hs_edge = hs_act & ~hs_q;
    vs_edge = vs_act & ~vs_q;

    // Predicted coordinates: what the free-running counters reach this tick.
    x_wrap  = (x_q == HLast);
    x_pred  = x_wrap ? 10'd0 : x_q + 10'd1;
    y_pred  = x_wrap ? ((y_q == VLast) ? 10'd0 : y_q + 10'd1) : y_q;
    h_match = (x_pred == HSyncStart);
    v_match = (y_pred == VSyncStart);
    timeout = !hs_edge && (wd_q == WdLast);

    state_d = state_q;
    x_d     = x_pred;
    y_d     = y_pred;
    good_d  = good_q;
    err_inc = 1'b0;
    wd_d    = (hs_edge || timeout) ? 11'd0 : wd_q + 11'd1;

    if (timeout) begin
      state_d = StSearch;
      good_d  = '0;
      err_inc = (state_q == StLocked);
    end else begin
      unique case (state_q)
        StSearch: begin
          if (hs_edge) begin
            x_d     = HSyncStart;
            good_d  = '0;
            state_d = StSyncH;
          end
        end
        StSyncH: begin
          if (hs_edge) begin
            if (h_match) begin
              good_d = good_q + CntW'(1);
              if (good_q == GoodLast) state_d = StSyncV;
            end else begin
              x_d    = HSyncStart;
              good_d = '0;
            end
          end
        end
        StSyncV: begin
          if (hs_edge && !h_match) begin
            x_d     = HSyncStart;
            good_d  = '0;
            state_d = StSyncH;
          end else if (vs_edge) begin
            y_d     = VSyncStart;
            state_d = StLocked;
          end
        end
        StLocked: begin
          // A simultaneous vsync mismatch is folded into the hsync error.
          if (hs_edge && !h_match) begin
            err_inc = 1'b1;
            x_d     = HSyncStart;
            good_d  = '0;
            state_d = StSyncH;
          end else if (vs_edge && !v_match) begin
            err_inc = 1'b1;
            y_d     = VSyncStart;
            state_d = StSyncV;
          end
        end
        default: state_d = StSearch;
      endcase
    end

    err_d      = (err_inc && (err_q != 8'hff)) ? err_q + 8'd1 : err_q;
    video_on_d = (state_d == StLocked) && (x_d < HDisp) && (y_d < VDisp);
    pix_d      = video_on_d ? rgb_i : 12'h000;
    fs_d       = (state_d == StLocked) && (x_d == 10'd0) && (y_d == 10'd0);
  end

  // State and output registers, advanced only on pixel ticks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StSearch;
      x_q        <= '0;
      y_q        <= '0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      good_q     <= '0;
      wd_q       <= '0;
      err_q      <= '0;
      video_on_q <= 1'b0;
      pix_q      <= '0;
      fs_q       <= 1'b0;
    end else if (p_tick_i) begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hs_q       <= hs_act;
      vs_q       <= vs_act;
      good_q     <= good_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      video_on_q <= video_on_d;
      pix_q      <= pix_d;
      fs_q       <= fs_d;
    end else begin
      fs_q       <= 1'b0;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign video_on_o    = video_on_q;
  assign pix_rgb_o     = pix_q;
  assign frame_start_o = fs_q;
  assign locked_o      = (state_q == StLocked);
  assign err_count_o   = err_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx with a reduced raster (24x15 total, 16x10 visible).
// Stimulus queues tick-stamped expectations; a monitor pops and compares them.
module tb_vga_timing_rx;

  localparam int HD  = 16;
  localparam int HSS = 18;
  localparam int HT  = 24;
  localparam int VD  = 10;
  localparam int VSS = 12;
  localparam int VT  = 15;
  localparam logic POL = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        p_tick = 1'b0;
  logic        hsync = ~POL;
  logic        vsync = ~POL;
  logic [11:0] rgb = 12'h000;
  logic [9:0]  x, y;
  logic        video_on, frame_start, locked;
  logic [11:0] pix_rgb;
  logic [7:0]  err_count;

  vga_timing_rx #(
    .H_DISPLAY(HD), .H_SYNC_START(HSS), .H_TOTAL(HT),
    .V_DISPLAY(VD), .V_SYNC_START(VSS), .V_TOTAL(VT),
    .SYNC_POL(1), .LOCK_LINES(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .p_tick_i(p_tick), .hsync_i(hsync), .vsync_i(vsync),
    .rgb_i(rgb), .x_o(x), .y_o(y), .video_on_o(video_on), .pix_rgb_o(pix_rgb),
    .frame_start_o(frame_start), .locked_o(locked), .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  typedef enum int {KX, KY, KLock, KErr, KVonV, KPixV, KVonCnt, KFsCnt, KPixCnt, KMaxX,
                    KMaxY} kind_e;
  typedef struct {
    int unsigned at;
    kind_e       kind;
    int unsigned want;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0, n_bad = 0;
  int unsigned stim_n = 0, mon_n = 0;
  int unsigned von_cnt = 0, fs_cnt = 0, pix_cnt = 0, max_x = 0, max_y = 0;

  // Transmitter model and stimulus knobs.
  int tx_x = 0, tx_y = 0;
  bit hs_off = 0, hs_delay = 0, vs_fast = 0;
  int pix_x = -1, pix_y = -1;

  function automatic string kname(input kind_e k);
    case (k)
      KX:      return "x";
      KY:      return "y";
      KLock:   return "locked";
      KErr:    return "err_count";
      KVonV:   return "video_on";
      KPixV:   return "pix_rgb";
      KVonCnt: return "video_on_ticks";
      KFsCnt:  return "frame_start_clks";
      KPixCnt: return "pix_nonzero_ticks";
      KMaxX:   return "max_x";
      default: return "max_y";
    endcase
  endfunction

  task automatic expect_at(input int unsigned at, input kind_e k, input int unsigned v);
    exp_t e;
    e.at = at; e.kind = k; e.want = v;
    sb_q.push_back(e);
  endtask

  task automatic check(input exp_t e);
    int unsigned act;
    act = 0;
    case (e.kind)
      KX:      act = 32'(x);
      KY:      act = 32'(y);
      KLock:   act = 32'(locked);
      KErr:    act = 32'(err_count);
      KVonV:   act = 32'(video_on);
      KPixV:   act = 32'(pix_rgb);
      KVonCnt: begin act = von_cnt; von_cnt = 0; end
      KFsCnt:  begin act = fs_cnt;  fs_cnt  = 0; end
      KPixCnt: begin act = pix_cnt; pix_cnt = 0; end
      KMaxX:   act = max_x;
      default: act = max_y;
    endcase
    n_cmp++;
    if (act != e.want) begin
      n_bad++;
      $display("FAIL %s @tick %0d: got %0d, want %0d", kname(e.kind), e.at, act, e.want);
    end
  endtask

  // One pixel tick: drive the source for (tx_x, tx_y), pulse p_tick for one clk.
  task automatic tick();
    bit ha, va;
    int hs_lo;
    @(negedge clk);
    hs_lo = hs_delay ? HSS + 1 : HSS;
    ha = !hs_off && (tx_x >= hs_lo) && (tx_x < hs_lo + 3);
    if (vs_fast) va = ((tx_x >= 2) && (tx_x < 5)) || ((tx_x >= 20) && (tx_x < 23));
    else         va = (tx_y >= VSS) && (tx_y < VSS + 2);
    hsync  = ha ? POL : ~POL;
    vsync  = va ? POL : ~POL;
    rgb    = ((tx_x == pix_x) && (tx_y == pix_y)) ? 12'h3f0 : 12'h000;
    p_tick = 1'b1;
    @(negedge clk);
    p_tick = 1'b0;
    stim_n++;
    if (tx_x == HT - 1) begin
      tx_x = 0;
      tx_y = (tx_y == VT - 1) ? 0 : tx_y + 1;
    end else begin
      tx_x = tx_x + 1;
    end
  endtask

  task automatic run_to(input int unsigned n);
    while (stim_n < n) tick();
  endtask

  // Monitor: samples #1 after each clk edge, compares due expectations on ticks.
  initial begin
    bit   was_tick;
    exp_t e;
    forever begin
      @(posedge clk);
      was_tick = p_tick;
      #1;
      if (frame_start) fs_cnt++;
      if (was_tick) begin
        if (video_on) von_cnt++;
        if (pix_rgb != 12'h000) pix_cnt++;
        if (32'(x) > max_x) max_x = 32'(x);
        if (32'(y) > max_y) max_y = 32'(y);
        while (sb_q.size() > 0 && sb_q[0].at <= mon_n) begin
          e = sb_q.pop_front();
          if (e.at < mon_n) begin
            n_cmp++; n_bad++;
            $display("FAIL %s @tick %0d: missed, want %0d", kname(e.kind), e.at, e.want);
          end else begin
            check(e);
          end
        end
        mon_n++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: stim tick %0d, want 9362", stim_n);
    $fatal(1, "simulation time limit");
  end

  initial begin
    #1 rst_n = 1'b0;

    // Reset held while the source runs into mid-frame; release at (5,5).
    expect_at(2, KX, 0);     expect_at(2, KY, 0);    expect_at(2, KLock, 0);
    expect_at(2, KErr, 0);   expect_at(2, KVonV, 0); expect_at(2, KPixV, 0);
    run_to(125);
    rst_n = 1'b1;
    expect_at(137, KX, 13);  expect_at(137, KY, 0);
    expect_at(138, KX, 18);  expect_at(138, KLock, 0);
    expect_at(234, KLock, 0);
    expect_at(287, KLock, 0);
    expect_at(288, KLock, 1); expect_at(288, KX, 0); expect_at(288, KY, 12);
    expect_at(288, KErr, 0);
    expect_at(359, KVonCnt, 0); expect_at(359, KFsCnt, 0);
    expect_at(487, KX, 7);   expect_at(487, KY, 5);
    expect_at(719, KVonCnt, 160); expect_at(719, KFsCnt, 1);
    run_to(720);

    // Single lit pixel inside the visible area.
    pix_x = 5; pix_y = 3;
    expect_at(796, KPixV, 0);
    expect_at(797, KPixV, 32'h3f0); expect_at(797, KVonV, 1);
    expect_at(798, KPixV, 0);
    expect_at(1079, KVonCnt, 160); expect_at(1079, KFsCnt, 1); expect_at(1079, KPixCnt, 1);
    run_to(1080);

    // Same pixel colour in the horizontal blanking region.
    pix_x = 20; pix_y = 3;
    expect_at(1172, KPixV, 0); expect_at(1172, KVonV, 0);
    expect_at(1172, KX, 20);   expect_at(1172, KY, 3);
    expect_at(1439, KVonCnt, 160); expect_at(1439, KFsCnt, 1); expect_at(1439, KPixCnt, 0);
    expect_at(1439, KMaxX, 23); expect_at(1439, KMaxY, 14);
    expect_at(1439, KLock, 1);  expect_at(1439, KErr, 0);
    run_to(1488);
    pix_x = -1; pix_y = -1;

    // One hsync pulse late by a tick on line 2 of frame 4.
    hs_delay = 1;
    expect_at(1506, KLock, 1);
    expect_at(1507, KErr, 1); expect_at(1507, KLock, 0); expect_at(1507, KX, 18);
    run_to(1512);
    hs_delay = 0;
    expect_at(1529, KX, 16);  expect_at(1530, KX, 18);
    expect_at(1727, KLock, 0);
    expect_at(1728, KLock, 1); expect_at(1728, KY, 12); expect_at(1728, KErr, 1);
    run_to(1867);

    // Hsync held inactive: watchdog fires 48 ticks after the last edge.
    hs_off = 1;
    expect_at(1913, KLock, 1); expect_at(1913, KErr, 1);
    expect_at(1914, KLock, 0); expect_at(1914, KErr, 2);
    expect_at(1962, KLock, 0); expect_at(1967, KErr, 2);
    run_to(1968);
    hs_off = 0;
    expect_at(1986, KX, 18);  expect_at(1986, KLock, 0);
    expect_at(2087, KLock, 0);
    expect_at(2088, KLock, 1); expect_at(2088, KY, 12); expect_at(2088, KErr, 2);
    run_to(2160);

    // Vsync edges at x=2 and x=20 each line: one LOCKED mismatch per line.
    vs_fast = 1;
    expect_at(2162, KErr, 3);   expect_at(2162, KLock, 0);
    expect_at(2180, KLock, 1);  expect_at(2180, KY, 12);
    expect_at(2186, KErr, 4);   expect_at(2186, KLock, 0);
    expect_at(8186, KErr, 254); expect_at(8210, KErr, 255); expect_at(8234, KErr, 255);
    expect_at(9359, KErr, 255); expect_at(9359, KMaxX, 23); expect_at(9359, KMaxY, 14);
    run_to(9360);

    // Asynchronous reset clears the error counter and coordinates.
    rst_n = 1'b0;
    expect_at(9360, KErr, 0);  expect_at(9360, KX, 0);    expect_at(9360, KY, 0);
    expect_at(9360, KLock, 0); expect_at(9360, KVonV, 0); expect_at(9360, KPixV, 0);
    run_to(9362);

    repeat (4) @(posedge clk);
    #2;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL %s @tick %0d: never compared, want %0d", kname(e.kind), e.at, e.want);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_rx.md
# vga_timing_rx

Receive-side counterpart of `vga_sync`: samples a VGA stream (hsync, vsync, 12-bit rgb) at the pixel-tick rate and recovers the pixel coordinates. It locks onto the sync timing and flags timing errors. It sits on the capture/debug side of the display path: it is driven by a board's pong video output and feeds a frame checker or second display.

## Interface
Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_SYNC_START, 656, transmitter x at hsync leading edge
- H_TOTAL, 800, pixels per line
- V_DISPLAY, 480, visible lines
- V_SYNC_START, 490, transmitter y at vsync leading edge
- V_TOTAL, 525, lines per frame
- SYNC_POL, 1, active level of hsync/vsync (1 matches `vga_sync`)
- LOCK_LINES, 4, consecutive good lines required before vertical search

Ports:
- clk, in, 1, system clock (100 MHz)
- reset, in, 1, asynchronous, active-low reset
- p_tick, in, 1, pixel enable, one clk wide, 25 MHz
- hsync, in, 1, horizontal sync from source
- vsync, in, 1, vertical sync from source
- rgb, in, 12, pixel colour from source
- x, out, 10, recovered column
- y, out, 10, recovered row
- video_on, out, 1, locked and in the visible area
- pix_rgb, out, 12, captured colour; 0 outside the visible area
- frame_start, out, 1, one-clk pulse at (0,0) while locked
- locked, out, 1, full H+V lock
- err_count, out, 8, saturating timing-error count

## Operation
- Everything except reset advances only on clk edges where p_tick=1.
- Sync sampling:
  - hs_act = (hsync==SYNC_POL); vs_act likewise.
  - One register of previous sampled levels.
  - A leading edge is inactive→active.
- Free-running counters:
  - x increments each tick and wraps H_TOTAL-1→0.
  - On wrap, y increments and wraps V_TOTAL-1→0.
- FSM states: SEARCH, SYNC_H, SYNC_V, LOCKED.
  - SEARCH: on an hsync edge, load x=H_SYNC_START, clear good-line count, go to SYNC_H.
  - SYNC_H: on an hsync edge, compare with the predicted x (the value x would take this tick).
    - Match: good count +1. When it reaches LOCK_LINES, go to SYNC_V.
    - Mismatch: reload x=H_SYNC_START and clear the count.
  - SYNC_V: an hsync mismatch returns to SYNC_H (reload x). On a vsync edge, load y=V_SYNC_START and go to LOCKED.
  - LOCKED:
    - hsync mismatch: err_count +1, reload x=H_SYNC_START, go to SYNC_H.
    - vsync edge where predicted y≠V_SYNC_START: err_count +1, load y=V_SYNC_START, go to SYNC_V.
    - Both mismatch on the same tick: count one error, take the hsync path.
- Timeout: the hsync watchdog (11 bits) counts ticks since the last hsync edge. At 2*H_TOTAL it returns the FSM to SEARCH from any state and clears the count. This counts as an error only if the FSM was LOCKED.
- locked = (state==LOCKED).
- video_on = locked && x<H_DISPLAY && y<V_DISPLAY.
- pix_rgb = video_on ? rgb : 0, registered in the same tick as x/y.
- frame_start = 1 for exactly one clk when locked && x==0 && y==0.
- err_count saturates at 255. Only reset clears it.

## Timing
- Reset (asynchronous, active-low): x=0, y=0, video_on=0, pix_rgb=0, frame_start=0, locked=0, err_count=0, FSM=SEARCH, sync history = inactive.
- Reset asserted mid-frame clears immediately. Recovery restarts from SEARCH on release.
- All outputs are registered. x, y, video_on, pix_rgb, locked and frame_start change only on p_tick cycles; frame_start deasserts the following clk.
- When the hsync edge is sampled at tick n, x=H_SYNC_START is visible after the edge of tick n. That coordinate describes the rgb sampled on tick n.
- Lock latency from the first hsync edge: LOCK_LINES lines, plus the wait to the next vsync edge, plus 1 tick.
- When an hsync edge and an x wrap coincide, the load has priority over the increment. A vsync load has priority over the y increment.

## Test plan
- Drive `vga_sync` into the block, release reset mid-frame. Required: x=656 right after the first hsync edge, locked=0 through 4 lines, locked=1 with y=490 at the first vsync edge, err_count=0.
- Run 3 locked frames. Required: frame_start pulses exactly once per 420,000 ticks, 307,200 video_on ticks per frame, x never exceeds 799, y never exceeds 524.
- Delay one hsync pulse by 1 tick while locked. Required: err_count=1, locked=0, x reloaded to 656, relock at the next vsync edge.
- Hold hsync inactive for 1600 ticks. Required: FSM in SEARCH, locked=0, err_count incremented by 1.
- Drive rgb=12'h3f0 only at (100,50), 12'h000 elsewhere. Required: pix_rgb=12'h3f0 only when x=100 and y=50. Repeat with the same pixel outside the visible area (700,50): pix_rgb=0.
- Inject 300 hsync mismatches. Required: err_count stops at 255. Asserting reset returns it to 0.
